// File: rtl/uart_buffered.sv
`default_nettype none
// ============================================================================
//  Module      : uart_buffered
//  Description : Full-duplex UART with TX and RX FIFOs, optional parity,
//                sticky parity/frame/overrun error flags.
//  Revision    : 1.0 - initial release
// ============================================================================

// Synchronous FIFO, first-word fall-through, pointers wrap modulo DEPTH.
module uart_buffered_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    // Full/empty gating uses the occupancy before this edge, so a push into a
    // full FIFO is refused even when a pop happens on the same edge.
    assign do_push = push_i && (count_q != c_depth);
    assign do_pop  = pop_i && (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage array; contents need no reset because occupancy guards reads.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

module uart_buffered #(
    parameter int CLOCK_FREQ = 1_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [DATA_BITS-1:0]            data_in,
    input  logic                            data_in_valid,
    output logic                            data_in_ready,
    output logic [DATA_BITS-1:0]            data_out,
    output logic                            data_out_valid,
    input  logic                            data_out_ready,
    input  logic                            serial_in,
    output logic                            serial_out,
    input  logic                            i_err_clr,
    output logic                            o_parity_err,
    output logic                            o_frame_err,
    output logic                            o_overrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_tx_count,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_rx_count
);
    localparam int DIV   = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W = $clog2(DIV+1);
    localparam int BIT_W = 4;
    localparam int CW    = $clog2(FIFO_DEPTH+1);

    localparam logic [CNT_W-1:0] c_div_last = CNT_W'(DIV-1);
    localparam logic [CNT_W-1:0] c_div_half = CNT_W'(DIV/2-1);
    localparam logic [BIT_W-1:0] c_bit_last = BIT_W'(DATA_BITS-1);
    localparam logic [CW-1:0]    c_depth    = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity bit that makes the frame even (PARITY=1) or odd (PARITY=2).
    function automatic logic par_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 2) ? ~(^d) : ^d;
    endfunction

    // ------------------------------------------------------------------ FIFOs
    logic [DATA_BITS-1:0] tx_head;
    logic                 tx_pop;
    logic                 rx_word_valid;

    uart_buffered_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .push_i  (data_in_valid),
        .data_i  (data_in),
        .pop_i   (tx_pop),
        .data_o  (tx_head),
        .count_o (o_tx_count)
    );

    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;

    uart_buffered_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .push_i  (rx_word_valid),
        .data_i  (rx_shift_q),
        .pop_i   (data_out_ready),
        .data_o  (data_out),
        .count_o (o_rx_count)
    );

    assign data_in_ready  = (o_tx_count != c_depth);
    assign data_out_valid = (o_rx_count != '0);

    // -------------------------------------------------------------------- TX
    state_t               tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_line;
    logic                 serial_out_q;
    logic                 tx_tick;
    logic                 tx_have;

    assign tx_tick    = (tx_cnt_q == c_div_last);
    assign tx_have    = (o_tx_count != '0);
    assign serial_out = serial_out_q;

    // TX next-state: load from FIFO head in IDLE or directly at the end of
    // STOP so consecutive frames abut without an idle gap.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                tx_cnt_d = '0;
                if (tx_have) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_par_d   = par_of(tx_head);
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                tx_cnt_d = tx_cnt_q + CNT_W'(1);
                if (tx_tick) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_cnt_d = tx_cnt_q + CNT_W'(1);
                if (tx_tick) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + BIT_W'(1);
                    if (tx_bit_q == c_bit_last)
                        tx_state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                tx_cnt_d = tx_cnt_q + CNT_W'(1);
                if (tx_tick) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                tx_cnt_d = tx_cnt_q + CNT_W'(1);
                if (tx_tick) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_IDLE;
                    if (tx_have) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_par_d   = par_of(tx_head);
                        tx_state_d = ST_START;
                    end
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    // Line level implied by the current TX state.
    always_comb begin
        tx_line = 1'b1;
        case (tx_state_q)
            ST_START:  tx_line = 1'b0;
            ST_DATA:   tx_line = tx_shift_q[0];
            ST_PARITY: tx_line = tx_par_q;
            default:   tx_line = 1'b1;
        endcase
    end

    // TX registers; the line is registered one clock behind the state, which
    // places the start bit two clocks after the accepting edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            tx_state_q   <= ST_IDLE;
            tx_cnt_q     <= '0;
            tx_bit_q     <= '0;
            tx_shift_q   <= '0;
            tx_par_q     <= 1'b0;
            serial_out_q <= 1'b1;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            tx_par_q     <= tx_par_d;
            serial_out_q <= tx_line;
        end
    end

    // -------------------------------------------------------------------- RX
    state_t           rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0] rx_bit_q, rx_bit_d;
    logic             rx_par_q, rx_par_d;
    logic             armed_q, armed_d;
    logic             sync1_q, sync2_q;
    logic             rx_tick;
    logic             rx_frame_evt;
    logic             rx_par_evt;
    logic             rx_par_bad;
    logic             overrun_evt;

    assign rx_tick    = (rx_cnt_q == c_div_last);
    assign rx_par_bad = (PARITY != 0) && (rx_par_q != par_of(rx_shift_q));

    // Two-flop synchronizer for the asynchronous serial input.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
        end
    end

    // RX next-state: a falling edge is a low level seen while armed; arming
    // requires a high sample, so a stuck-low line after a frame error waits.
    always_comb begin
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        rx_par_d      = rx_par_q;
        armed_d       = armed_q;
        rx_word_valid = 1'b0;
        rx_frame_evt  = 1'b0;
        rx_par_evt    = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                rx_cnt_d = '0;
                if (sync2_q)
                    armed_d = 1'b1;
                else if (armed_q)
                    rx_state_d = ST_START;
            end
            ST_START: begin
                rx_cnt_d = rx_cnt_q + CNT_W'(1);
                if (rx_cnt_q == c_div_half) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = sync2_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                rx_cnt_d = rx_cnt_q + CNT_W'(1);
                if (rx_tick) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {sync2_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_bit_d   = rx_bit_q + BIT_W'(1);
                    if (rx_bit_q == c_bit_last)
                        rx_state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                rx_cnt_d = rx_cnt_q + CNT_W'(1);
                if (rx_tick) begin
                    rx_cnt_d   = '0;
                    rx_par_d   = sync2_q;
                    rx_state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                rx_cnt_d = rx_cnt_q + CNT_W'(1);
                if (rx_tick) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_IDLE;
                    if (!sync2_q) begin
                        rx_frame_evt = 1'b1;
                        armed_d      = 1'b0;
                    end else if (rx_par_bad) begin
                        rx_par_evt = 1'b1;
                    end else begin
                        rx_word_valid = 1'b1;
                    end
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    // RX registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            armed_q    <= armed_d;
        end
    end

    // ------------------------------------------------------------ error flags
    assign overrun_evt = rx_word_valid && (o_rx_count == c_depth);

    // Sticky flags: a new event on the clearing edge keeps the flag set.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_parity_err <= rx_par_evt   | (o_parity_err & ~i_err_clr);
            o_frame_err  <= rx_frame_evt | (o_frame_err  & ~i_err_clr);
            o_overrun    <= overrun_evt  | (o_overrun    & ~i_err_clr);
        end
    end
endmodule
`default_nettype wire
